// File: rtl/mux_nx1_rr_pkg.sv
// Shared definitions for the N:1 round-robin/manual multiplexer family.
//   MODE_MANUAL / MODE_RR : encodings of the mode input
//   calc_selw             : width of a channel index for n channels (min 1)
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int calc_selw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Handshake bundle between N producer channels, the mux and one consumer.
//   in_data/in_valid/in_ready : per-channel producer side
//   mode/sel                  : channel selection control
//   out_data/out_valid/out_ready/out_ch : consumer side
// slave modport is the mux view; master modport is the producer/consumer view.
interface mux_nx1_rr_if
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 1
);
    localparam int SELW = calc_selw(N);

    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SELW-1:0] out_ch;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

endinterface

// File: rtl/mux_nx1_rr_rr_grant.sv
// Combinational rotate-priority encoder.
//   req       : request vector
//   ptr       : index with highest priority; priority falls off ptr+1, ptr+2 ... wrapping at N
//   gnt_valid : some request is present
//   gnt_idx   : winning index (0 when gnt_valid is low)
module rr_grant
    import mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SELW = calc_selw(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    always_comb begin
        int j;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        // Walk from lowest to highest priority so the closest request to ptr wins last.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            for (int i = 0; i < N; i++) begin
                if (i == j && req[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SELW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// N:1 multiplexer with a single registered output stage and valid/ready flow
// control on every channel. Selection is either the external sel (manual) or a
// round-robin scan starting at rr_ptr.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : handshake bundle (slave view), see mux_nx1_rr_if
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 1,
    localparam int SELW = calc_selw(N)
) (
    input  logic         clk,
    input  logic         rst,
    mux_nx1_rr_if.slave  bus
);

    logic [SELW-1:0] rr_ptr;
    logic            rr_valid;
    logic [SELW-1:0] rr_idx;
    logic            man_valid;
    logic            gnt_valid;
    logic [SELW-1:0] gnt_idx;
    logic            load_en;
    logic            load;
    logic [W-1:0]    sel_data;
    logic [W-1:0]    out_data_q;
    logic            out_valid_q;
    logic [SELW-1:0] out_ch_q;

    rr_grant #(.N(N)) u_rr_grant (
        .req       (bus.in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Out-of-range sel values match no channel and so never grant.
    always_comb begin
        man_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                man_valid = 1'b1;
            end
        end
    end

    always_comb begin
        if (bus.mode == MODE_RR) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else begin
            gnt_valid = man_valid;
            gnt_idx   = bus.sel;
        end
    end

    assign load_en = !out_valid_q || bus.out_ready;
    assign load    = !rst && load_en && gnt_valid;

    // Unselected channels contribute zero so their X's cannot leak into out_data.
    always_comb begin
        sel_data     = '0;
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_valid && gnt_idx == SELW'(i)) begin
                sel_data        = bus.in_data[i*W +: W];
                bus.in_ready[i] = load;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr      <= '0;
        end else begin
            if (load) begin
                out_data_q  <= sel_data;
                out_ch_q    <= gnt_idx;
                out_valid_q <= 1'b1;
                if (bus.mode == MODE_RR) begin
                    rr_ptr <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed self-checking bench for mux_nx1_rr: N=4/W=8, N=3/W=8 and N=4/W=1 instances.
module tb_mux_nx1_rr;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [7:0] d4 [4];
    logic [7:0] d3 [3];

    mux_nx1_rr_if #(.N(4), .W(8)) b4 ();
    mux_nx1_rr_if #(.N(3), .W(8)) b3 ();
    mux_nx1_rr_if #(.N(4), .W(1)) b1 ();

    mux_nx1_rr #(.N(4), .W(8)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    mux_nx1_rr #(.N(3), .W(8)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
    mux_nx1_rr #(.N(4), .W(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b4.in_valid = 4'b1111;
        step();
        total++; if (b4.in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", b4.in_ready); end
        total++; if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", b4.out_valid); end
        total++; if (b4.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", b4.out_data); end
        total++; if (b4.out_ch !== 2'd0) begin bad++; $display("FAIL reset_out_ch got=%0d exp=0", b4.out_ch); end
        rst = 1'b0;
        b4.in_valid = 4'b0000;
        step();
    endtask

    task automatic test_manual();
        b4.mode = 1'b0;
        b4.sel = 2'd2;
        b4.in_valid = 4'b0100;
        b4.out_ready = 1'b1;
        #1;
        total++; if (b4.in_ready !== 4'b0100) begin bad++; $display("FAIL manual_in_ready got=%b exp=0100", b4.in_ready); end
        step();
        total++; if (b4.out_data !== 8'hA5) begin bad++; $display("FAIL manual_out_data got=%h exp=a5", b4.out_data); end
        total++; if (b4.out_ch !== 2'd2) begin bad++; $display("FAIL manual_out_ch got=%0d exp=2", b4.out_ch); end
        total++; if (b4.out_valid !== 1'b1) begin bad++; $display("FAIL manual_out_valid got=%b exp=1", b4.out_valid); end
        b4.sel = 2'd1;
        #1;
        total++; if (b4.in_ready !== 4'b0000) begin bad++; $display("FAIL manual_noreq_in_ready got=%b exp=0000", b4.in_ready); end
        step();
        total++; if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL manual_drop_valid got=%b exp=0", b4.out_valid); end
        total++; if (b4.out_data !== 8'hA5) begin bad++; $display("FAIL manual_hold_data got=%h exp=a5", b4.out_data); end
    endtask

    task automatic rr_run(input logic [3:0] valid, input int n, input int s0, input int s1,
                          input int s2, input int s3, input int s4, input int s5);
        int seq [6];
        seq = '{s0, s1, s2, s3, s4, s5};
        b4.in_valid = valid;
        for (int k = 0; k < n; k++) begin
            #1;
            total++; if (b4.in_ready !== 4'(1 << seq[k])) begin bad++; $display("FAIL rr_in_ready[%0d] got=%b exp_ch=%0d", k, b4.in_ready, seq[k]); end
            step();
            total++; if (b4.out_ch !== 2'(seq[k])) begin bad++; $display("FAIL rr_out_ch[%0d] got=%0d exp=%0d", k, b4.out_ch, seq[k]); end
            total++; if (b4.out_data !== d4[seq[k]]) begin bad++; $display("FAIL rr_out_data[%0d] got=%h exp=%h", k, b4.out_data, d4[seq[k]]); end
            total++; if (b4.out_valid !== 1'b1) begin bad++; $display("FAIL rr_out_valid[%0d] got=%b exp=1", k, b4.out_valid); end
        end
    endtask

    task automatic test_rr_scan();
        b4.mode = 1'b1;
        b4.out_ready = 1'b1;
        rr_run(4'b1111, 6, 0, 1, 2, 3, 0, 1);
        rr_run(4'b1001, 4, 3, 0, 3, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        // Held beat is ch0 (0x11); rr_ptr sits at 1 with in_valid=1001.
        b4.out_ready = 1'b0;
        #1;
        total++; if (b4.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready got=%b exp=0000", b4.in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (b4.out_data !== 8'h11) begin bad++; $display("FAIL bp_hold_data[%0d] got=%h exp=11", k, b4.out_data); end
            total++; if (b4.out_ch !== 2'd0) begin bad++; $display("FAIL bp_hold_ch[%0d] got=%0d exp=0", k, b4.out_ch); end
            total++; if (b4.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", k, b4.out_valid); end
            total++; if (b4.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0000", k, b4.in_ready); end
        end
        b4.out_ready = 1'b1;
        #1;
        total++; if (b4.in_ready !== 4'b1000) begin bad++; $display("FAIL bp_release_ready got=%b exp=1000", b4.in_ready); end
        step();
        total++; if (b4.out_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid got=%b exp=1", b4.out_valid); end
        total++; if (b4.out_ch !== 2'd3) begin bad++; $display("FAIL bp_release_ch got=%0d exp=3", b4.out_ch); end
        total++; if (b4.out_data !== 8'h44) begin bad++; $display("FAIL bp_release_data got=%h exp=44", b4.out_data); end
    endtask

    task automatic test_reset_midstream();
        // rr_ptr is 0 here; loading ch2 moves it to 3 before reset hits.
        b4.in_valid = 4'b0100;
        #1;
        total++; if (b4.in_ready !== 4'b0100) begin bad++; $display("FAIL mid_pre_ready got=%b exp=0100", b4.in_ready); end
        step();
        total++; if (b4.out_ch !== 2'd2) begin bad++; $display("FAIL mid_pre_ch got=%0d exp=2", b4.out_ch); end
        rst = 1'b1;
        #1;
        total++; if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", b4.out_valid); end
        total++; if (b4.out_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h exp=00", b4.out_data); end
        total++; if (b4.out_ch !== 2'd0) begin bad++; $display("FAIL mid_rst_ch got=%0d exp=0", b4.out_ch); end
        total++; if (b4.in_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0000", b4.in_ready); end
        step();
        rst = 1'b0;
        b4.in_valid = 4'b1111;
        #1;
        total++; if (b4.in_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr_ready got=%b exp=0001", b4.in_ready); end
        step();
        total++; if (b4.out_ch !== 2'd0) begin bad++; $display("FAIL mid_ptr_ch got=%0d exp=0", b4.out_ch); end
        total++; if (b4.out_data !== 8'h11) begin bad++; $display("FAIL mid_ptr_data got=%h exp=11", b4.out_data); end
        b4.in_valid = 4'b0000;
        step();
    endtask

    task automatic test_n3();
        int seq [4];
        seq = '{0, 1, 2, 0};
        b3.mode = 1'b1;
        b3.out_ready = 1'b1;
        b3.in_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (b3.out_ch !== 2'(seq[k])) begin bad++; $display("FAIL n3_rr_ch[%0d] got=%0d exp=%0d", k, b3.out_ch, seq[k]); end
            total++; if (b3.out_data !== d3[seq[k]]) begin bad++; $display("FAIL n3_rr_data[%0d] got=%h exp=%h", k, b3.out_data, d3[seq[k]]); end
        end
        b3.mode = 1'b0;
        b3.sel = 2'd3;
        #1;
        total++; if (b3.in_ready !== 3'b000) begin bad++; $display("FAIL n3_sel3_ready got=%b exp=000", b3.in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (b3.out_valid !== 1'b0) begin bad++; $display("FAIL n3_sel3_valid[%0d] got=%b exp=0", k, b3.out_valid); end
            total++; if (b3.in_ready !== 3'b000) begin bad++; $display("FAIL n3_sel3_ready[%0d] got=%b exp=000", k, b3.in_ready); end
        end
    endtask

    task automatic test_sweep();
        logic [5:0] vv;
        logic [3:0] dv;
        logic [1:0] sv;
        b1.mode = 1'b0;
        b1.out_ready = 1'b1;
        b1.in_valid = 4'b1111;
        for (int v = 0; v < 64; v++) begin
            vv = 6'(v);
            dv = vv[3:0];
            sv = vv[5:4];
            b1.sel = sv;
            b1.in_data = dv;
            step();
            total++; if (b1.out_data !== dv[sv]) begin bad++; $display("FAIL sweep_data sel=%0d data=%b got=%b exp=%b", sv, dv, b1.out_data, dv[sv]); end
            total++; if (b1.out_ch !== sv) begin bad++; $display("FAIL sweep_ch sel=%0d got=%0d", sv, b1.out_ch); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        d4 = '{8'h11, 8'h22, 8'hA5, 8'h44};
        d3 = '{8'h30, 8'h31, 8'h32};
        rst = 1'b1;
        b4.in_data = {d4[3], d4[2], d4[1], d4[0]};
        b4.in_valid = '0; b4.mode = 1'b0; b4.sel = '0; b4.out_ready = 1'b1;
        b3.in_data = {d3[2], d3[1], d3[0]};
        b3.in_valid = '0; b3.mode = 1'b0; b3.sel = '0; b3.out_ready = 1'b1;
        b1.in_data = '0;
        b1.in_valid = '0; b1.mode = 1'b0; b1.sel = '0; b1.out_ready = 1'b1;

        test_reset();
        test_manual();
        test_rr_scan();
        test_backpressure();
        test_reset_midstream();
        test_n3();
        test_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
- Parametrised N:1 multiplexer with registered output and valid/ready handshake on every input and on the output.
- Two channel-selection modes: manual (external select, as in the existing 4:1 mux) and round-robin scan across requesting channels.
- Sits between several producer channels and one consumer.
- Successor to the combinational 4:1 mux: generalised in channel count and width, and adds buffering, flow control and fair arbitration.

Parameters:
- N, 4, number of input channels (N >= 2; need not be a power of 2).
- W, 1, data width per channel in bits.
- SELW, $clog2(N), select/channel-index width; localparam, never overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; combinational, at most one bit high (one-hot or zero).
- mode  in  1  0 = manual, 1 = round-robin.
- sel  in  SELW  channel select, used in manual mode only.
- out_data  out  W  registered selected data.
- out_valid  out  1  output holds an unconsumed beat.
- out_ready  in  1  consumer accepts beat.
- out_ch  out  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets out_data=0, out_valid=0, out_ch=0, rr_ptr=0. in_ready is 0 while rst is high.
- Output stage is a single register.
  - load_en = !out_valid || out_ready.
  - Transfer on input i when in_valid[i] && in_ready[i].
  - Transfer on output when out_valid && out_ready.
- Grant selection (combinational):
  - Manual: grant = sel if sel < N and in_valid[sel]; otherwise no grant. sel >= N never grants.
  - Round-robin: grant = first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... modulo N (wrap N-1 -> 0). No valid channel means no grant.
- in_ready[i] = load_en && grant valid && grant == i.
- On load: out_data <= channel data, out_ch <= grant, out_valid <= 1.
- If there is no load but the output is consumed: out_valid <= 0; out_data and out_ch hold their values.
- If out_valid && !out_ready: the register holds, and all in_ready bits are 0 (stall; no input is lost).
- Simultaneous output consumption and new load in the same cycle: the new beat replaces the old one and out_valid stays 1. Full throughput is 1 beat/cycle.
- Latency: input transfer at edge k gives out_valid/out_data visible after edge k (one cycle).
- rr_ptr update:
  - Only on a load in round-robin mode, rr_ptr <= (grant == N-1) ? 0 : grant+1.
  - Manual-mode loads leave rr_ptr unchanged.
- Mode or sel changes take effect in the same cycle's grant computation. They never disturb a beat already held in the output register.
- Reset asserted mid-stream: the held beat is discarded immediately and rr_ptr returns to 0.
- The design is stateless apart from out_data, out_valid, out_ch and rr_ptr. No latch inference and no X propagation from unselected channels.

Decomposition:
- Package mux_pkg holds MODE_MANUAL = 1'b0 and MODE_RR = 1'b1, plus a function for the SELW calculation if the tool flow needs one.
- One sub-module, rr_grant, is natural. It is a combinational rotate-priority encoder: inputs req[N-1:0] and ptr[SELW-1:0]; outputs gnt_valid and gnt_idx[SELW-1:0]. It is reusable by future arbiters.
- Top level holds the output register, rr_ptr, and the manual/round-robin grant mux.

Test Plan:
1. Reset with N=4, W=8: assert rst mid-run while out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately; in_ready=0000 while rst is high.
2. Manual mode, sel=2, in_valid=0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=0100; next cycle out_data=A5, out_ch=2, out_valid=1. Then sel=1 with in_valid[1]=0 -> in_ready=0000 and out_valid drops to 0.
3. Round-robin mode, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, one beat per cycle. Then in_valid=1001 -> sequence 3,0,3,0.
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable and in_ready=0000; on release, the held beat is consumed and a new beat loads in the same cycle, with out_valid staying 1.
5. N=3 (non-power-of-2): round-robin with all valid -> out_ch 0,1,2,0. Manual sel=3 -> never grants, out_valid stays 0.
6. Exhaustive sweep as for the 4:1 mux: N=4, W=1, manual mode, out_ready=1, loop {sel, in_data} over all 64 values -> out_data one cycle later equals in_data[sel] every time.
